// File: rtl/fetch_instr_queue.sv
// Instruction buffer between fetch and decode: compacts sparse fetch groups into a circular buffer and
// presents the oldest DEQ_WIDTH entries to decode. Latency is 1 cycle, or 0 cycles with IFQ_BYPASS_EN.
// Backpressure: fetch_ready_o drops when fewer than ENQ_WIDTH slots are free, and decode pops only the ready prefix.
// Optional feature macro: IFQ_BYPASS_EN (empty-queue fetch-to-decode bypass).

module fetch_instr_queue #(
  parameter int XLEN      = 32,
  parameter int ILEN      = 32,
  parameter int ENQ_WIDTH = 4,
  parameter int DEQ_WIDTH = 2,
  parameter int DEPTH     = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic [ENQ_WIDTH-1:0]           fetch_valid_i,
  input  logic [ENQ_WIDTH*ILEN-1:0]      fetch_instr_i,
  input  logic [ENQ_WIDTH*XLEN-1:0]      fetch_pc_i,
  output logic                           fetch_ready_o,
  output logic [DEQ_WIDTH-1:0]           deq_valid_o,
  output logic [DEQ_WIDTH*ILEN-1:0]      deq_instr_o,
  output logic [DEQ_WIDTH*XLEN-1:0]      deq_pc_o,
  input  logic [DEQ_WIDTH-1:0]           deq_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH+1);
  localparam int ECW = $clog2(ENQ_WIDTH+1);
  localparam int DCW = $clog2(DEQ_WIDTH+1);

  // Entry payload storage; deliberately not reset.
  logic [ILEN-1:0] r_instr [DEPTH];
  logic [XLEN-1:0] r_pc    [DEPTH];

  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CW-1:0]   r_count;

  logic [ECW-1:0]  w_pre [ENQ_WIDTH];   // number of valid lanes below lane i
  logic [ECW-1:0]  w_enq_n;             // popcount of the fetch mask
  logic [ILEN-1:0] w_cmp_instr [ENQ_WIDTH];
  logic [XLEN-1:0] w_cmp_pc    [ENQ_WIDTH];
  logic            w_enq_fire;
  logic [DCW-1:0]  w_deq_n;             // total lanes popped this cycle
  logic [CW-1:0]   w_byp_pop;           // popped lanes that came straight from fetch
  logic [CW-1:0]   w_st_pop;            // popped lanes that came from storage

  // Eligibility looks only at the registered count so a group is taken whole or not at all.
  assign fetch_ready_o = (r_count <= CW'(DEPTH - ENQ_WIDTH));
  assign w_enq_fire    = fetch_ready_o && (|fetch_valid_i) && !flush_i;
  assign count_o       = r_count;

  // Running prefix count of valid lanes gives each valid lane its compacted slot.
  always_comb begin
    w_enq_n = '0;
    for (int i = 0; i < ENQ_WIDTH; i++) begin
      w_pre[i] = w_enq_n;
      if (fetch_valid_i[i]) w_enq_n = w_enq_n + ECW'(1);
    end
  end

  // Compact valid lanes into slots 0..w_enq_n-1 preserving lane order.
  always_comb begin
    for (int k = 0; k < ENQ_WIDTH; k++) begin
      w_cmp_instr[k] = '0;
      w_cmp_pc[k]    = '0;
      for (int i = 0; i < ENQ_WIDTH; i++) begin
        if (fetch_valid_i[i] && (w_pre[i] == ECW'(k))) begin
          w_cmp_instr[k] = fetch_instr_i[i*ILEN +: ILEN];
          w_cmp_pc[k]    = fetch_pc_i[i*XLEN +: XLEN];
        end
      end
    end
  end

  // Decode lanes show the oldest stored entries, optionally followed by bypassed fetch slots.
  always_comb begin
    deq_valid_o = '0;
    deq_instr_o = '0;
    deq_pc_o    = '0;
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      if (CW'(j) < r_count) begin
        deq_valid_o[j]              = 1'b1;
        deq_instr_o[j*ILEN +: ILEN] = r_instr[r_head + PW'(j)];
        deq_pc_o[j*XLEN +: XLEN]    = r_pc[r_head + PW'(j)];
      end
`ifdef IFQ_BYPASS_EN
      else begin
        for (int k = 0; k < ENQ_WIDTH; k++) begin
          if (w_enq_fire && (k < int'(w_enq_n)) && (int'(r_count) + k == j)) begin
            deq_valid_o[j]              = 1'b1;
            deq_instr_o[j*ILEN +: ILEN] = w_cmp_instr[k];
            deq_pc_o[j*XLEN +: XLEN]    = w_cmp_pc[k];
          end
        end
      end
`endif
    end
  end

  // Pop count is the leading run of valid-and-ready lanes; anything past the first gap stays.
  always_comb begin
    logic w_run;
    w_run   = 1'b1;
    w_deq_n = '0;
    for (int j = 0; j < DEQ_WIDTH; j++) begin
      if (w_run && deq_valid_o[j] && deq_ready_i[j]) w_deq_n = w_deq_n + DCW'(1);
      else                                           w_run   = 1'b0;
    end
  end

  // Split the pops between storage and the bypass path; bypassed pops never touch storage.
  always_comb begin
`ifdef IFQ_BYPASS_EN
    w_byp_pop = (CW'(w_deq_n) > r_count) ? (CW'(w_deq_n) - r_count) : '0;
`else
    w_byp_pop = '0;
`endif
    w_st_pop = CW'(w_deq_n) - w_byp_pop;
  end

  // Pointer and occupancy update; flush wins over any concurrent traffic.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head <= r_head + PW'(w_st_pop);
      if (w_enq_fire) r_tail <= r_tail + PW'(CW'(w_enq_n) - w_byp_pop);
      r_count <= r_count + (w_enq_fire ? CW'(w_enq_n) : '0) - CW'(w_deq_n);
    end
  end

  // Write the compacted slots not consumed by bypass at tail, tail+1, ...
  always_ff @(posedge clk_i) begin
    if (w_enq_fire) begin
      for (int k = 0; k < ENQ_WIDTH; k++) begin
        if ((ECW'(k) < w_enq_n) && (CW'(k) >= w_byp_pop)) begin
          r_instr[r_tail + PW'(CW'(k) - w_byp_pop)] <= w_cmp_instr[k];
          r_pc[r_tail + PW'(CW'(k) - w_byp_pop)]    <= w_cmp_pc[k];
        end
      end
    end
  end

`ifndef SYNTHESIS
  logic [DEQ_WIDTH-1:0] w_vld_inc;
  assign w_vld_inc = deq_valid_o + DEQ_WIDTH'(1);

  // Occupancy never exceeds capacity and the decode valid mask is always a prefix.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i) r_count <= CW'(DEPTH));
  a_prefix_mask: assert property (@(posedge clk_i) disable iff (rst_i) (deq_valid_o & w_vld_inc) == '0);
`endif

endmodule

// File: doc/fetch_instr_queue.md
Name: fetch_instr_queue

Overview:
- Parametrised instruction buffer between the fetch stage and decode.
- Accepts up to ENQ_WIDTH (= INSTR_PER_FETCH) instructions per cycle with a per-lane valid mask, compacts them, and stores them in program order in a circular buffer of DEPTH entries.
- Presents up to DEQ_WIDTH oldest entries to decode each cycle.
- Supports a full flush for redirects and mispredicts.

Parameters:
- XLEN, 32, PC width in bits.
- ILEN, 32, instruction width in bits.
- ENQ_WIDTH, 4, fetch lanes per cycle; matches INSTR_PER_FETCH of the user config.
- DEQ_WIDTH, 2, decode lanes per cycle; must satisfy 1 <= DEQ_WIDTH <= DEPTH.
- DEPTH, 16, entry count; power of two, >= ENQ_WIDTH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous active-high reset.
- flush_i  in  1  discard all contents; takes priority over enqueue and dequeue.
- fetch_valid_i  in  ENQ_WIDTH  per-lane valid mask; may be non-contiguous.
- fetch_instr_i  in  ENQ_WIDTH*ILEN  lane i instruction at bits [i*ILEN +: ILEN].
- fetch_pc_i  in  ENQ_WIDTH*XLEN  lane i PC.
- fetch_ready_o  out  1  high when free entries >= ENQ_WIDTH.
- deq_valid_o  out  DEQ_WIDTH  lane j holds the j-th oldest entry; always a prefix mask.
- deq_instr_o  out  DEQ_WIDTH*ILEN  instruction per decode lane.
- deq_pc_o  out  DEQ_WIDTH*XLEN  PC per decode lane.
- deq_ready_i  in  DEQ_WIDTH  decode acceptance per lane; only the prefix is honoured.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- **Reset.** Head, tail and count = 0; deq_valid_o = 0; fetch_ready_o = 1; count_o = 0. Entry payloads are not reset.
- **Enqueue handshake.**
  - Fires when fetch_ready_o && |fetch_valid_i && !flush_i.
  - All-or-nothing per group: fetch_ready_o depends only on registered count, never on same-cycle dequeue.
  - Valid lanes are written in ascending lane order to tail, tail+1, ... (mod DEPTH).
  - tail advances by popcount(fetch_valid_i).
  - A group with mask 0 is a no-op.
  - If fetch_ready_o = 0, the group is ignored and fetch must hold it.
- **Dequeue.**
  - deq_valid_o[j] = (j < count).
  - Lane j pops when deq_valid_o[j] && deq_ready_i[k] for all k <= j. Pop count = length of that leading run.
  - Lanes after the first not-ready lane are not consumed, even if ready.
  - head advances by the pop count (mod DEPTH).
- **Latency.** An enqueued entry is visible on deq_* the cycle after enqueue (1-cycle latency) when IFQ_BYPASS_EN is undefined.
- **Simultaneous enqueue and dequeue.** count_next = count + enq_n - deq_n. Enqueue eligibility uses the pre-dequeue count, so a full-minus-3 queue with DEPTH=16 and ENQ_WIDTH=4 (count 13) refuses the group even if decode pops 2 that cycle.
- **Wrap-around.** Pointers are $clog2(DEPTH) bits and wrap naturally. Count disambiguates full from empty. count = DEPTH means full, with fetch_ready_o = 0.
- **Flush.**
  - On a cycle with flush_i = 1: head = tail = count = 0 at the next edge.
  - Any concurrent enqueue and dequeue are discarded and no pop is counted.
  - deq_valid_o stays as computed from the current count during the flush cycle; decode must ignore it.
- **Reset mid-operation.** Asynchronous clear of pointers and count. Outputs reach reset values immediately, independent of the clock.
- **No-overflow invariant.** count never exceeds DEPTH. An assertion (simulation only) checks count <= DEPTH and that deq_valid_o is a prefix mask.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- **Defined:**
  - When count < DEQ_WIDTH, decode lanes beyond the stored entries are filled combinationally from the current compacted fetch group, provided fetch_ready_o && !flush_i.
  - Bypassed lanes that are popped are not written into storage. Remaining lanes of the group are written at tail as usual.
  - Empty-queue latency becomes 0 cycles.
  - Ordering is preserved: stored entries always precede bypassed lanes.
- **Undefined:** no combinational path from fetch_* to deq_*. Latency is 1 cycle.

Test Plan:
- **Reset then single group.** Reset, then enqueue mask 4'b1111 with PCs 0x100–0x10C. Next cycle: deq lanes show 0x100 and 0x104 and count_o = 4. Pop both: next cycle shows 0x108 and 0x10C, count_o = 2.
- **Sparse mask compaction.** Mask 4'b1010 with PCs 0x200, 0x204, 0x208, 0x20C. Stored order is 0x204 then 0x20C; count_o = 2.
- **Fill to full.** Enqueue 4 full groups with deq_ready_i = 0. count_o = 16, fetch_ready_o = 0. A fifth group is ignored and count_o stays 16.
- **Prefix dequeue with wrap.** Drive the queue so head = 14 with 6 entries, then apply deq_ready_i = 2'b10. No pop occurs. Then apply 2'b11 over 3 cycles: entries exit in order across the 15→0 index wrap.
- **Flush with concurrent traffic.** count = 5; in the same cycle assert flush_i, a 4-lane enqueue and deq_ready_i = 2'b11. Next cycle: count_o = 0, deq_valid_o = 0, fetch_ready_o = 1.
- **Asynchronous reset mid-stream.** With count = 9, pulse rst_i between clock edges. count_o and deq_valid_o drop to 0 before the next edge. With IFQ_BYPASS_EN defined and the queue empty, an enqueue of mask 4'b0011 appears on deq lanes in the same cycle.
